// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - MDU op codes and op-class helpers shared by decoder and MDU
package mult_div_unit_pkg;

  localparam int MDU_OP_SIZE = 4;

  typedef enum logic [MDU_OP_SIZE-1:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MTHI  = 4'd5,
    MDU_OP_MTLO  = 4'd6,
    MDU_OP_MFHI  = 4'd7,
    MDU_OP_MFLO  = 4'd8
  } mdu_op_e;

  function automatic logic is_mult_op(input logic [MDU_OP_SIZE-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_SIZE-1:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

  function automatic logic is_md_op(input logic [MDU_OP_SIZE-1:0] op);
    return is_mult_op(op) || is_div_op(op);
  endfunction

  function automatic logic is_signed_op(input logic [MDU_OP_SIZE-1:0] op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  endfunction

  // Ops that change state when accepted; MF* and NONE/unknown never do.
  function automatic logic is_accept_op(input logic [MDU_OP_SIZE-1:0] op);
    return is_md_op(op) || (op == MDU_OP_MTHI) || (op == MDU_OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_compute.sv
// rtl/mdu_compute.sv - combinational 64-bit product and quotient/remainder with div-by-zero flag
module mdu_compute (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] divisor;
  logic [31:0] uq;
  logic [31:0] ur;

  // Low 64 bits of the extended product are correct for both signednesses.
  assign a_ext   = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
  assign b_ext   = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
  assign product = a_ext * b_ext;

  // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  assign a_neg       = is_signed & a[31];
  assign b_neg       = is_signed & b[31];
  assign abs_a       = a_neg ? (32'd0 - a) : a;
  assign abs_b       = b_neg ? (32'd0 - b) : b;
  assign div_by_zero = (b == 32'd0);
  assign divisor     = div_by_zero ? 32'd1 : abs_b;
  assign uq          = abs_a / divisor;
  assign ur          = abs_a % divisor;
  assign quotient    = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
  assign remainder   = a_neg ? (32'd0 - ur) : ur;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - E-stage multiply/divide unit holding HI/LO with fixed-latency commit
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        cancel,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] read_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             busy_reg;
  logic [63:0]      pend;
  logic             pend_we;
  logic             accept;
  logic [63:0]      product;
  logic [31:0]      quotient;
  logic [31:0]      remainder;
  logic             div_by_zero;

  mdu_compute u_compute (
    .is_signed   (is_signed_op(op)),
    .a           (rs_data),
    .b           (rt_data),
    .product     (product),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  assign accept = start && !cancel && !busy_reg && is_accept_op(op);
  // cancel stays out of busy so the exception path never reaches the stall logic.
  assign busy   = busy_reg || (start && is_md_op(op));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      busy_reg <= 1'b0;
      pend     <= '0;
      pend_we  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (accept && is_md_op(op)) begin
      cnt      <= is_mult_op(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      busy_reg <= 1'b1;
      pend     <= is_mult_op(op) ? product : {remainder, quotient};
      pend_we  <= is_mult_op(op) || !div_by_zero;
    end else if (accept) begin
      if (op == MDU_OP_MTHI) hi <= rs_data;
      if (op == MDU_OP_MTLO) lo <= rs_data;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy_reg <= 1'b0;
        if (pend_we) {hi, lo} <= pend;
      end
    end
  end

  always_comb begin
    read_data = 32'd0;
    case (op)
      MDU_OP_MFHI: read_data = hi;
      MDU_OP_MFLO: read_data = lo;
      default:     read_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = MDU_OP_NONE;
  logic        cancel = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;
  int violations = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .cancel    (cancel),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .read_data (read_data)
  );

  always #5 clk = ~clk;

  // Protocol monitor: a start while an operation is in flight is a hazard-controller bug.
  always @(posedge clk) begin
    if (!reset && start && dut.busy_reg) begin
      violations++;
      $display("protocol: start while busy_reg at %0t", $time);
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk); #1;
    start = 1'b1; op = v.op; rs_data = v.rs; rt_data = v.rt;
    @(negedge clk);
    chk($sformatf("v%0d busy_t0", idx), {31'b0, busy}, (v.n > 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    start = 1'b0; op = MDU_OP_NONE;
    for (int i = 1; i <= v.n; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d busy_c%0d", idx, i), {31'b0, busy}, 32'd1);
      chk($sformatf("v%0d hi_hold_c%0d", idx, i), hi, m_hi);
      chk($sformatf("v%0d lo_hold_c%0d", idx, i), lo, m_lo);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk($sformatf("v%0d busy_done", idx), {31'b0, busy}, 32'd0);
    chk($sformatf("v%0d hi", idx), hi, v.hi);
    chk($sformatf("v%0d lo", idx), lo, v.lo);
    m_hi = v.hi;
    m_lo = v.lo;
  endtask

  initial begin
    vecs[0] = '{MDU_OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[2] = '{MDU_OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        10};
    vecs[3] = '{MDU_OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{MDU_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{MDU_OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[6] = '{MDU_OP_MTHI,  32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 32'hFFFFFFFD, 0};
    vecs[7] = '{MDU_OP_MTLO,  32'h000000BB, 32'd0,        32'hDEADBEEF, 32'h000000BB, 0};
    vecs[8] = '{MDU_OP_MTHI,  32'h000000AA, 32'd0,        32'h000000AA, 32'h000000BB, 0};
    vecs[9] = '{MDU_OP_DIV,   32'h12345678, 32'd0,        32'h000000AA, 32'h000000BB, 10};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      run_vec(vecs[k], k);
    end

    // MF* reads combinationally in the same cycle.
    @(posedge clk); #1;
    op = MDU_OP_MFHI; start = 1'b1;
    #1 chk("mfhi read", read_data, 32'h000000AA);
    chk("mfhi busy", {31'b0, busy}, 32'd0);
    op = MDU_OP_MFLO;
    #1 chk("mflo read", read_data, 32'h000000BB);
    op = MDU_OP_NONE;
    #1 chk("none read", read_data, 32'd0);
    op = 4'hF;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_OP_NONE;
    @(negedge clk);
    chk("unknown op busy", {31'b0, busy}, 32'd0);
    chk("unknown op hi", hi, 32'h000000AA);

    // Cancelled start: busy pulses but nothing is loaded.
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = MDU_OP_MULT; rs_data = 32'd3; rt_data = 32'd3;
    @(negedge clk);
    chk("cancel busy_t0", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; op = MDU_OP_NONE;
    @(negedge clk);
    chk("cancel busy_t1", {31'b0, busy}, 32'd0);
    chk("cancel hi", hi, 32'h000000AA);
    chk("cancel lo", lo, 32'h000000BB);

    // Second start mid-flight is ignored; original product commits on time.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_OP_MULT; rs_data = 32'd2; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_OP_NONE;
    @(posedge clk); #1;
    start = 1'b1; op = MDU_OP_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_OP_NONE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovl busy_t0+5", {31'b0, busy}, 32'd1);
    chk("ovl hi_hold", hi, 32'h000000AA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ovl busy_t0+6", {31'b0, busy}, 32'd0);
    chk("ovl hi", hi, 32'd0);
    chk("ovl lo", lo, 32'd6);
    chk("ovl violation flagged", violations, 32'd1);

    // Async reset mid-operation aborts and suppresses the commit.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_OP_MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_OP_NONE;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rst nocommit hi %0d", i), hi, 32'd0);
      chk($sformatf("rst nocommit lo %0d", i), lo, 32'd0);
      chk($sformatf("rst nocommit busy %0d", i), {31'b0, busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit holding the architectural HI/LO registers.
- Drives the `E_busy` input of the hazard controller, which stalls the D-stage when `D_request && E_busy`.
- The D-stage side produces `D_request`. This block asserts busy from the start cycle through the last compute cycle, and commits HI/LO only when the operation finishes.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU after the start edge.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU after the start edge.

Ports:
- clk  in  1  system clock. One clock domain; reset is asynchronous, active-high.
- reset  in  1  asynchronous active-high reset.
- start  in  1  E-stage instruction is an MDU instruction (decoder-qualified).
- op  in  4  `MDU_OP_*` code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NONE.
- cancel  in  1  M-stage exception/interrupt taken this cycle; suppresses the start.
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- busy  out  1  to the hazard controller as `E_busy`.
- hi  out  32  committed HI register.
- lo  out  32  committed LO register.
- read_data  out  32  MFHI→hi, MFLO→lo, otherwise 0 (combinational).

Behaviour:
- **Reset values (async):** hi=0, lo=0, counter=0, pending result=0, busy_reg=0. read_data follows hi/lo.
- **Accepted start:** `accept = start && !cancel && !busy_reg && op∈{MULT,MULTU,DIV,DIVU,MTHI,MTLO}`.
- **busy output:** `busy = busy_reg || (start && op∈{MULT,MULTU,DIV,DIVU})`. This is combinational on start, so an MF*/MT*/MD instruction in D stalls in the same cycle. cancel is deliberately excluded, which keeps exception logic out of the path.
- **MULT/MULTU at edge t0:**
  - Compute the 64-bit product (signed or unsigned) into pending {hi,lo}.
  - Load counter=MULT_CYCLES; busy_reg=1.
- **DIV/DIVU:**
  - LO=quotient, truncated toward zero. HI=remainder, sign of dividend.
  - Counter loads DIV_CYCLES.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
- **Divide by zero:** still busy for DIV_CYCLES; HI/LO unchanged at completion.
- **Countdown:**
  - Counter decrements each edge while nonzero. busy_reg=1 while counter≠0.
  - The edge where counter goes 1→0 writes pending into hi/lo.
  - busy is high for exactly N cycles after t0 (cycles t0+1..t0+N). New HI/LO is visible from cycle t0+N+1, together with busy=0.
- **MTHI/MTLO:** accepted write of rs_data to hi/lo at the edge. No busy, no counter.
- **MFHI/MFLO:** read-only, no state change.
- **cancel:**
  - cancel=1 blocks the start: no state change, counter not loaded. busy may still have pulsed high that cycle; this is harmless.
  - cancel never aborts an in-flight operation.
- **start while busy_reg=1:** protocol violation (the hazard controller prevents it). It is ignored and the in-flight operation is unaffected. The bench flags it with an assertion.
- **op=NONE or unknown with start:** no effect.
- **Reset mid-operation:** immediate abort. busy=0, hi=lo=0, and no later commit occurs.
- The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES), i.e. `$clog2(max+1)`.

Decomposition:
- `MDU_OP_SIZE` and the `MDU_OP_*` codes go in `macros.v`, next to the `T_SIZE`/`FWD_*` definitions. The decoder and this block share them.
- One natural sub-module: `mdu_compute`. It is a purely combinational 64-bit signed/unsigned product and quotient/remainder with the div-by-zero flag.
- mult_div_unit keeps the counter, pending register and commit logic.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5, start at t0:
  - busy=1 in cycle t0 (comb) and t0+1..t0+5.
  - At t0+6, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
  - hi/lo unchanged before t0+6.
- DIVU rs=7, rt=2:
  - busy for 10 cycles, then lo=3, hi=1.
  - Same rs/rt with DIV rs=0xFFFFFFF9 (-7), rt=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV rs=0x12345678, rt=0, with hi=0xAA, lo=0xBB beforehand → busy 10 cycles, then hi=0xAA, lo=0xBB.
- MTHI rs=0xDEADBEEF:
  - Next cycle hi=0xDEADBEEF, busy stays 0.
  - Then op=MFHI: read_data=0xDEADBEEF in the same cycle.
- MULT start with cancel=1 → busy=1 that cycle only, counter stays 0, hi/lo unchanged next cycle.
- MULT started, reset asserted at t0+2 (async, mid-cycle) → busy=0, hi=lo=0 immediately and no commit at t0+6. A second start during busy_reg=1 is ignored (assertion fires).
